// File: rtl/uop_pkg.sv
// rtl/uop_pkg.sv - uop tag encoding and capability classification shared by rename blocks
package uop_pkg;

    typedef enum logic [2:0] {
        UOP_INT_ALU       = 3'd0,
        UOP_ST_U8         = 3'd1,
        UOP_PACK_ADD_SAT  = 3'd2,
        UOP_PREFIX_SELECT = 3'd3,
        UOP_CAP_JUMP      = 3'd4,
        UOP_LINK          = 3'd5,
        UOP_CAP_LOAN_END  = 3'd6
    } uop_tag_t;

    function automatic logic uop_is_capability(input uop_tag_t tag);
        case (tag)
            UOP_PREFIX_SELECT,
            UOP_CAP_JUMP,
            UOP_LINK,
            UOP_CAP_LOAN_END: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dispatch_cap_popcount.sv
// rtl/dispatch_cap_popcount.sv - counts capability uops among the taken issue-lane prefix
module dispatch_cap_popcount #(
    parameter int ISSUE_WIDTH = 2,
    parameter int TW          = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic [ISSUE_WIDTH-1:0] cap_i,
    input  logic [TW-1:0]          take_i,
    output logic [TW-1:0]          pop_o
);

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if ((TW'(i) < take_i) && cap_i[i]) begin
                pop_o = pop_o + TW'(1);
            end
        end
    end

endmodule

// File: rtl/rename_dispatch_buffer.sv
// rtl/rename_dispatch_buffer.sv - circular uop buffer between decode and issue
// with capability tagging, saturating capability-issued counter and flush.
module rename_dispatch_buffer
    import uop_pkg::*;
#(
    parameter int MAX_UOPS    = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             decode_valid_i,
    input  uop_tag_t                         decode_uops_i [MAX_UOPS],
    input  logic [$clog2(MAX_UOPS+1)-1:0]    decode_uop_count_i,
    output logic                             rename_ready_o,
    output logic [ISSUE_WIDTH-1:0]           issue_valid_o,
    output uop_tag_t                         issue_uop_o [ISSUE_WIDTH],
    output logic [ISSUE_WIDTH-1:0]           issue_is_capability_o,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0] issue_take_i,
    input  logic                             flush_i,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy_o,
    output logic [CNT_W-1:0]                 capability_issued_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(MAX_UOPS + 1);
    localparam int TW    = $clog2(ISSUE_WIDTH + 1);

    uop_tag_t          mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_sum;
    logic [TW-1:0]     cap_pop;
    logic              enq_fire;
    logic [CW-1:0]     enq_cnt;

    dispatch_cap_popcount #(
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_cap_popcount (
        .cap_i  (issue_is_capability_o),
        .take_i (issue_take_i),
        .pop_o  (cap_pop)
    );

    always_comb begin
        rename_ready_o = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(MAX_UOPS);
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            issue_valid_o[i]         = OCC_W'(i) < occ_q;
            issue_uop_o[i]           = mem_q[head_q + PTR_W'(i)];
            issue_is_capability_o[i] = issue_valid_o[i] && uop_is_capability(issue_uop_o[i]);
        end
        occupancy_o               = occ_q;
        capability_issued_count_o = cnt_q;

        enq_fire = decode_valid_i && rename_ready_o && !flush_i;
        enq_cnt  = enq_fire ? decode_uop_count_i : '0;
        cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(cap_pop);

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            head_d = tail_q;
            occ_d  = '0;
        end else begin
            head_d = head_q + PTR_W'(issue_take_i);
            tail_d = tail_q + PTR_W'(enq_cnt);
            occ_d  = occ_q + OCC_W'(enq_cnt) - OCC_W'(issue_take_i);
            // Clamp instead of wrapping once the sum spills into the carry bit.
            cnt_d  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
            if (enq_fire) begin
                for (int i = 0; i < MAX_UOPS; i++) begin
                    if (CW'(i) < decode_uop_count_i) begin
                        mem_q[tail_q + PTR_W'(i)] <= decode_uops_i[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_dispatch_buffer.sv
// tb/tb_rename_dispatch_buffer.sv - directed self-checking bench for rename_dispatch_buffer
module tb_rename_dispatch_buffer;
    import uop_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid;
    uop_tag_t   d_uops [2];
    logic [1:0] d_cnt;
    logic [1:0] take;
    logic       flush;

    logic       ready, s_ready;
    logic [1:0] ivalid, s_ivalid;
    uop_tag_t   iuop [2];
    uop_tag_t   s_iuop [2];
    logic [1:0] icap, s_icap;
    logic [3:0] occ, s_occ;
    logic [15:0] cnt;
    logic [1:0] s_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rename_dispatch_buffer dut (
        .clk_i (clk), .rst_ni (rst_n), .decode_valid_i (d_valid),
        .decode_uops_i (d_uops), .decode_uop_count_i (d_cnt),
        .rename_ready_o (ready), .issue_valid_o (ivalid), .issue_uop_o (iuop),
        .issue_is_capability_o (icap), .issue_take_i (take), .flush_i (flush),
        .occupancy_o (occ), .capability_issued_count_o (cnt)
    );

    rename_dispatch_buffer #(.CNT_W(2)) dut_sat (
        .clk_i (clk), .rst_ni (rst_n), .decode_valid_i (d_valid),
        .decode_uops_i (d_uops), .decode_uop_count_i (d_cnt),
        .rename_ready_o (s_ready), .issue_valid_o (s_ivalid), .issue_uop_o (s_iuop),
        .issue_is_capability_o (s_icap), .issue_take_i (take), .flush_i (flush),
        .occupancy_o (s_occ), .capability_issued_count_o (s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input uop_tag_t u0, input uop_tag_t u1, input logic [1:0] n);
        d_valid   = 1'b1;
        d_uops[0] = u0;
        d_uops[1] = u1;
        d_cnt     = n;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("proto_count", 32'(d_cnt <= 2'd2), 32'd1);
            chk("proto_take", 32'(take <= 2'($countones(ivalid))), 32'd1);
        end
    end

    uop_tag_t seq [7];

    initial begin
        seq = '{UOP_INT_ALU, UOP_ST_U8, UOP_PACK_ADD_SAT, UOP_PREFIX_SELECT,
                UOP_CAP_JUMP, UOP_LINK, UOP_CAP_LOAN_END};
        rst_n = 1'b0; d_valid = 1'b0; d_cnt = 2'd0; take = 2'd0; flush = 1'b0;
        d_uops[0] = UOP_INT_ALU; d_uops[1] = UOP_INT_ALU;
        step(); step();
        chk("rst_occ", occ, 0);
        chk("rst_ready", ready, 1);
        chk("rst_valid", ivalid, 0);
        chk("rst_cnt", cnt, 0);

        rst_n = 1'b1;
        enq(UOP_PREFIX_SELECT, UOP_ST_U8, 2'd2);
        step();
        d_valid = 1'b0;
        chk("enq_occ", occ, 2);
        chk("enq_valid", ivalid, 2'b11);
        chk("enq_cap0", icap[0], 1);
        chk("enq_cap1", icap[1], 0);
        chk("enq_uop0", iuop[0], UOP_PREFIX_SELECT);
        chk("enq_uop1", iuop[1], UOP_ST_U8);
        chk("enq_cnt", cnt, 0);

        take = 2'd2;
        step();
        take = 2'd0;
        chk("take_occ", occ, 0);
        chk("take_valid", ivalid, 0);
        chk("take_cnt", cnt, 1);
        chk("take_scnt", s_cnt, 1);

        enq(UOP_CAP_JUMP, UOP_LINK, 2'd2);
        step();
        d_valid = 1'b0;
        take = 2'd2;
        step();
        take = 2'd0;
        chk("take2_cnt", cnt, 3);
        chk("take2_scnt", s_cnt, 3);

        enq(UOP_INT_ALU, UOP_ST_U8, 2'd2);        step();
        enq(UOP_PACK_ADD_SAT, UOP_INT_ALU, 2'd2); step();
        enq(UOP_ST_U8, UOP_PACK_ADD_SAT, 2'd2);   step();
        chk("fill6_occ", occ, 6);
        chk("fill6_ready", ready, 1);
        enq(UOP_INT_ALU, UOP_INT_ALU, 2'd1);      step();
        chk("fill7_occ", occ, 7);
        chk("fill7_ready", ready, 0);
        enq(UOP_ST_U8, UOP_ST_U8, 2'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_occ", occ, 7);
            chk("hold_ready", ready, 0);
        end
        take = 2'd1;
        step();
        take = 2'd0;
        chk("rel_occ", occ, 6);
        chk("rel_ready", ready, 1);
        chk("rel_uop0", iuop[0], UOP_ST_U8);
        step();
        d_valid = 1'b0;
        chk("full_occ", occ, 8);
        chk("full_ready", ready, 0);
        chk("full_valid", ivalid, 2'b11);
        take = 2'd2;
        for (int k = 0; k < 4; k++) step();
        take = 2'd0;
        chk("drain_occ", occ, 0);
        chk("drain_cnt", cnt, 3);

        enq(seq[0], UOP_INT_ALU, 2'd1);
        step();
        chk("wrap_occ", occ, 1);
        chk("wrap_uop", iuop[0], seq[0]);
        for (int k = 1; k < 12; k++) begin
            enq(seq[k % 7], UOP_INT_ALU, 2'd1);
            take = 2'd1;
            step();
            chk("wrap_occ", occ, 1);
            chk("wrap_uop", iuop[0], seq[k % 7]);
        end
        d_valid = 1'b0;
        step();
        take = 2'd0;
        chk("wrap_end_occ", occ, 0);
        chk("wrap_cnt", cnt, 9);
        chk("wrap_scnt", s_cnt, 3);

        enq(UOP_CAP_LOAN_END, UOP_INT_ALU, 2'd2); step();
        enq(UOP_ST_U8, UOP_ST_U8, 2'd2);          step();
        chk("pre_flush_occ", occ, 4);
        chk("pre_flush_cap0", icap[0], 1);
        enq(UOP_CAP_JUMP, UOP_LINK, 2'd2);
        take = 2'd1;
        flush = 1'b1;
        step();
        flush = 1'b0; take = 2'd0; d_valid = 1'b0;
        chk("flush_occ", occ, 0);
        chk("flush_valid", ivalid, 0);
        chk("flush_cnt", cnt, 9);
        chk("flush_ready", ready, 1);
        step();
        chk("post_flush_occ", occ, 0);

        enq(UOP_CAP_JUMP, UOP_LINK, 2'd2);               step();
        enq(UOP_PREFIX_SELECT, UOP_CAP_LOAN_END, 2'd2);  step();
        enq(UOP_CAP_JUMP, UOP_INT_ALU, 2'd1);            step();
        d_valid = 1'b0;
        chk("sat_occ", occ, 5);
        take = 2'd2; step();
        chk("sat_cnt_a", cnt, 11);
        chk("sat_scnt_a", s_cnt, 3);
        step();
        chk("sat_cnt_b", cnt, 13);
        chk("sat_scnt_b", s_cnt, 3);
        take = 2'd1; step();
        take = 2'd0;
        chk("sat_cnt_c", cnt, 14);
        chk("sat_scnt_c", s_cnt, 3);
        chk("sat_end_occ", occ, 0);

        enq(UOP_INT_ALU, UOP_ST_U8, 2'd2);
        step();
        chk("mid_occ", occ, 2);
        rst_n = 1'b0;
        take = 2'd1;
        step();
        chk("mid_rst_occ", occ, 0);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_scnt", s_cnt, 0);
        chk("mid_rst_valid", ivalid, 0);
        chk("mid_rst_ready", ready, 1);
        d_valid = 1'b0; take = 2'd0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
